rom_arbiter: RTL and testbench

Two-port arbiter that shares the single synchronous game ROM (16-bit words, one-cycle registered read) between the video/sprite fetch engine (port 0, high priority) and the game-logic engine (port 1). It accepts at most one read per cycle with a valid/ready handshake and pipelines requests at full throughput. Each read returns to the port that issued it. A starvation guard guarantees port 1 progress. Addresses beyond the populated ROM depth are answered locally with zero data and an error pulse.

---
 rtl/rom_arbiter.sv | 123 ++++++++++++
 tb/tb_rom_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module   : rom_arbiter
// Brief    : Two-port priority arbiter sharing one registered-read game ROM,
//            with starvation guard for port 1 and local out-of-range replies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int MAX_HI = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  // Zero-extended so the range test cannot wrap when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] c_depth  = DEPTH[ADDR_W:0];
  localparam logic [3:0]      c_max_hi = MAX_HI[3:0];

  logic              w_force1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any_gnt;
  logic              w_sel_port;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_oob;

  logic [3:0]        r_hi_cnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_tag_valid;
  logic              r_tag_port;
  logic              r_tag_oob;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err0;
  logic              r_err1;
  logic              r_oob_q;

  // Grant decode: port 0 wins unless port 1 has been passed over MAX_HI times.
  always_comb begin
    w_force1   = req1 & (r_hi_cnt == c_max_hi);
    w_gnt0     = req0 & ~w_force1;
    w_gnt1     = req1 & (~req0 | w_force1);
    w_any_gnt  = w_gnt0 | w_gnt1;
    w_sel_port = w_gnt1;
    w_sel_addr = w_gnt1 ? addr1 : addr0;
    w_sel_oob  = ({1'b0, w_sel_addr} >= c_depth);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi_cnt <= '0;
    end else if (!req1 || w_gnt1) begin
      r_hi_cnt <= '0;
    end else if (w_gnt0 && (r_hi_cnt != c_max_hi)) begin
      r_hi_cnt <= r_hi_cnt + 4'd1;
    end
  end

  // Stage 1: ROM address plus a tag recording who owns the read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr  <= '0;
      r_tag_valid <= 1'b0;
      r_tag_port  <= 1'b0;
      r_tag_oob   <= 1'b0;
    end else begin
      r_tag_valid <= w_any_gnt;
      r_tag_port  <= w_sel_port;
      r_tag_oob   <= w_any_gnt & w_sel_oob;
      if (w_any_gnt && !w_sel_oob) begin
        r_rom_addr <= w_sel_addr;
      end
    end
  end

  // Stage 2: steer the response to its issuing port, aligned with rom_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      r_oob_q <= 1'b0;
    end else begin
      r_ack0  <= r_tag_valid & ~r_tag_port;
      r_ack1  <= r_tag_valid &  r_tag_port;
      r_err0  <= r_tag_valid & ~r_tag_port & r_tag_oob;
      r_err1  <= r_tag_valid &  r_tag_port & r_tag_oob;
      r_oob_q <= r_tag_valid & r_tag_oob;
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign err0     = r_err0;
  assign err1     = r_err1;
  assign rom_addr = r_rom_addr;
  assign rdata0   = (r_ack0 & ~r_oob_q) ? rom_data : '0;
  assign rdata1   = (r_ack1 & ~r_oob_q) ? rom_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module   : tb_rom_arbiter
// Brief    : Directed and randomized self-checking bench for rom_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;
  localparam int MAX_HI = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic              gnt0, gnt1, ack0, ack1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  rom_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_HI(MAX_HI)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle registered read.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge clk) rom_data <= mem[rom_addr[9:0]];

  typedef struct {
    int          due;
    bit          port;
    bit          err;
    logic [15:0] data;
  } rsp_t;

  rsp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          passed_over = 0;   // port-0 wins since port 1 last got served
  logic [15:0] exp_rom_addr = '0;
  bit          last_g0, last_g1;
  logic [9:0]  pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_a0, e_a1, e_e0, e_e1;
    logic [15:0] e_d0, e_d1;
    e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0; e_d0 = '0; e_d1 = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      rsp_t r;
      r = q.pop_front();
      if (r.port) begin e_a1 = 1; e_e1 = r.err; e_d1 = r.data; end
      else        begin e_a0 = 1; e_e0 = r.err; e_d0 = r.data; end
    end
    chk("ack0", 32'(ack0), 32'(e_a0));
    chk("ack1", 32'(ack1), 32'(e_a1));
    chk("err0", 32'(err0), 32'(e_e0));
    chk("err1", 32'(err1), 32'(e_e1));
    chk("rdata0", 32'(rdata0), 32'(e_d0));
    chk("rdata1", 32'(rdata1), 32'(e_d1));
    chk("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
  endtask

  // One clock cycle: check registered outputs, drive inputs, check grants.
  task automatic step(input bit r0, input logic [15:0] a0, input bit r1, input logic [15:0] a1);
    bit g0, g1, oob;
    logic [15:0] a;
    @(posedge clk); #1; cyc++;
    check_outputs();
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
    g1 = r1 && (!r0 || passed_over == MAX_HI);
    g0 = r0 && !g1;
    chk("gnt0", 32'(gnt0), 32'(g0));
    chk("gnt1", 32'(gnt1), 32'(g1));
    if (g0 || g1) begin
      a   = g1 ? a1 : a0;
      oob = (int'(a) >= DEPTH);
      q.push_back('{due: cyc + 2, port: g1, err: oob, data: oob ? 16'h0000 : mem[a[9:0]]});
      if (!oob) exp_rom_addr = a;
    end
    if (!r1 || g1) passed_over = 0;
    else if (g0 && passed_over < MAX_HI) passed_over++;
    last_g0 = g0; last_g1 = g1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1; req0 = 0; req1 = 0;
    #1;
    q.delete(); passed_over = 0; exp_rom_addr = '0;
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_err", 32'({err0, err1}), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 0);
    req0 = 1; #1;
    chk("rst_gnt0_comb", 32'(gnt0), 1);
    req0 = 0;
    repeat (n) begin
      @(posedge clk); #1; cyc++;
      chk("rst_hold_acks", 32'({ack0, ack1, err0, err1}), 0);
      chk("rst_hold_rom_addr", 32'(rom_addr), 0);
    end
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'h03FF;
      1:       return 16'h0400;
      2:       return 16'($urandom_range(1024, 65535));
      default: return 16'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    bit p0, p1;
    logic [15:0] pa0, pa1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    mem[5] = 16'hABCD;
    apply_reset(2);

    // Single read
    step(1, 16'h0005, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Streaming 0..7
    for (int i = 0; i < 8; i++) step(1, 16'(i), 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Contention: both held high for ten cycles
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 16'h0020, 1, 16'h0030);
      pat = {pat[8:0], last_g1};
    end
    chk("contention_seq", 32'(pat), 32'(10'b0000100001));
    repeat (3) step(0, 0, 0, 0);

    // Port 1 alone at the top in-range word
    step(0, 0, 1, 16'h03FF);
    repeat (3) step(0, 0, 0, 0);

    // Out of range after an access to 0x0010
    step(1, 16'h0010, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'h0400);
    repeat (3) step(0, 0, 0, 0);

    // Reset mid-flight
    step(1, 16'h0005, 0, 0);
    @(posedge clk); #1; cyc++;
    check_outputs();
    apply_reset(2);
    step(1, 16'h0005, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Randomized traffic, requests held until granted
    p0 = 0; p1 = 0; pa0 = '0; pa1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin p0 = 1; pa0 = rand_addr(); end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; pa1 = rand_addr(); end
      step(p0, pa0, p1, pa1);
      if (last_g0) p0 = 0;
      if (last_g1) p1 = 0;
    end
    repeat (3) step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
